controle_jogo_drone: RTL
========================

# controle_jogo_drone

Control unit of the drone simulator. It sequences the whole game: start, difficulty selection, lives selection, periodic movement ticks and collision/finish checks, then win/lose. It drives the position/obstacle datapath with one-cycle strobes and consumes its collision and end-of-course flags. It exports the state, mode and lives-related debug values that the top level routes to `db_estado`, `db_modo` and `colisao_counter_out`.

## Interface
- `TICK_FACIL`, 2000: movement period in cycles, easy mode (≥4).
- `TICK_MEDIO`, 1000: movement period, medium mode (≥4).
- `TICK_DIFICIL`, 500: movement period, hard mode (≥4).
- `clock`  in  1  single system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `iniciar`  in  1  level; starts a game from INICIAL, VENCEU or PERDEU.
- `controle`  in  2  00 none, 01 up/increment, 10 down/decrement, 11 treated as 00.
- `confirma`  in  1  level; rising edge confirms a menu choice.
- `colisao`  in  1  datapath flag, valid in VERIFICA.
- `fim_percurso`  in  1  datapath flag, valid in VERIFICA.
- `zera_jogo`  out  1  one-cycle pulse clearing datapath position/obstacles.
- `move_pulso`  out  1  one-cycle movement strobe.
- `move_dir`  out  2  `controle` sampled in the MOVE cycle, 11 forced to 00.
- `venceu`, `perdeu`  out  1 each  high while in VENCEU / PERDEU.
- `db_estado`  out  4  current state code.
- `db_modo`  out  2  selected mode (00 easy, 01 medium, 10 hard).
- `vidas`  out  3  remaining lives.
- `colisao_counter_out`  out  3  collisions this game, saturating at 7.

## Operation
- States and codes: INICIAL 0, PREPARA 1, ESCOLHE_MODO 2, ESCOLHE_VIDAS 3, AGUARDA_TICK 4, MOVE 5, VERIFICA 6, COLIDIU 7, VENCEU 8, PERDEU 9. Codes 10–15 go to INICIAL.
- INICIAL: on `iniciar`=1, go to PREPARA.
- PREPARA: one cycle with `zera_jogo`=1. Set modo←00, vidas←1, collision count←0. Go to ESCOLHE_MODO.
- ESCOLHE_MODO: a rising edge of `controle`=01 increments modo, wrapping 10→00. A rising edge of 10 decrements modo, wrapping 00→10. A `confirma` rising edge goes to ESCOLHE_VIDAS.
- ESCOLHE_VIDAS: an 01 edge does vidas+1, saturating at 7. A 10 edge does vidas−1, saturating at 1. A `confirma` rising edge goes to AGUARDA_TICK and clears the timer.
- Edge detection: registered previous `controle` and `confirma`, both reset to 0. An edge on `controle` is a change of value to 01 or 10. A transition 01→10 counts as one edge.
- AGUARDA_TICK: the timer counts up. After exactly Tmode−2 cycles in this state, go to MOVE. Tmode is selected by modo and latched on leaving ESCOLHE_VIDAS.
- MOVE: one cycle, `move_pulso`=1. Go to VERIFICA.
- VERIFICA: one cycle. `colisao` has priority over `fim_percurso`.
  - On collision: vidas−1 and count+1. If the new vidas is 0, go to PERDEU; otherwise go to COLIDIU.
  - If not a collision and `fim_percurso`=1: go to VENCEU.
  - Otherwise: go to AGUARDA_TICK, timer cleared.
- COLIDIU: one cycle, then AGUARDA_TICK with the timer cleared.
- VENCEU / PERDEU: all outputs held. `iniciar`=1 goes to PREPARA.
- `iniciar` is ignored in all other states. `controle` and `confirma` are ignored outside the two menu states, except for the `move_dir` sampling in MOVE.

## Timing
- Reset values:
  - State: INICIAL. Outputs `db_estado`=0, `db_modo`=00, `vidas`=1, `colisao_counter_out`=0.
  - All strobes, `venceu` and `perdeu` are 0. Edge registers are 0.
  - Reset mid-game aborts on the next edge. No strobe is emitted in that cycle.
- All outputs are registered or decoded from the state register only. No input-to-output combinational path exists.
- Move period with no collision: exactly Tmode cycles between `move_pulso` pulses. A collision cycle adds 1 cycle.
- A `confirma` held high through reset, or through the transition from ESCOLHE_MODO, produces no edge until it is released and pressed again.
- The first `move_pulso` occurs Tmode−1 cycles after the cycle in which the lives `confirma` edge is sampled.

## Structure
- Package `drone_pkg`:
  - state encoding constants;
  - mode codes MODO_FACIL/MEDIO/DIFICIL;
  - `controle` codes CTRL_NADA/SOBE/DESCE;
  - vidas limits 1 and 7.
- Sub-module `drone_tick_timer`: a counter with synchronous clear, an enable, a terminal-count input (Tmode−2) and a `fim` output.
- Edge detectors and the FSM stay inline.

## Test plan
- Reset held 10 cycles, then released → `db_estado`=0, `vidas`=1, `db_modo`=00, no strobes.
- `iniciar`; confirm mode 00; controle 01,00,01,00; confirm → `vidas`=3, `db_modo`=00, state 4. The first `move_pulso` arrives 1999 cycles after the lives-confirm edge; subsequent pulses come every 2000 cycles.
- Mode menu: three 10 edges from 00 → modo 10, 01, 00 (wrap). In hard mode the pulse spacing is 500. Lives menu: eight 01 edges → saturate at 7; ten 10 edges → 1.
- `colisao`=1 in VERIFICA with vidas=3 → vidas 2, count 1, state 7 for one cycle, then the next pulse 2001 cycles later. Three collisions total → PERDEU with `perdeu`=1 and vidas=0.
- `colisao` and `fim_percurso` both 1 with vidas=2 → collision taken, no `venceu`. `fim_percurso` alone → VENCEU. Then `iniciar` → PREPARA with a `zera_jogo` pulse and count 0.
- `controle`=10 sampled at MOVE → `move_dir`=10. `controle`=11 at MOVE → `move_dir`=00. Reset asserted in AGUARDA_TICK → INICIAL next cycle with no `move_pulso`.

Source files
------------

// File: rtl/drone_pkg.sv
// Shared encodings for the drone game controller: states, menu codes, lives limits.
package drone_pkg;

    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        PREPARA       = 4'd1,
        ESCOLHE_MODO  = 4'd2,
        ESCOLHE_VIDAS = 4'd3,
        AGUARDA_TICK  = 4'd4,
        MOVE          = 4'd5,
        VERIFICA      = 4'd6,
        COLIDIU       = 4'd7,
        VENCEU        = 4'd8,
        PERDEU        = 4'd9
    } estado_t;

    localparam logic [1:0] MODO_FACIL   = 2'b00;
    localparam logic [1:0] MODO_MEDIO   = 2'b01;
    localparam logic [1:0] MODO_DIFICIL = 2'b10;

    localparam logic [1:0] CTRL_NADA  = 2'b00;
    localparam logic [1:0] CTRL_SOBE  = 2'b01;
    localparam logic [1:0] CTRL_DESCE = 2'b10;

    localparam logic [2:0] VIDAS_MIN = 3'd1;
    localparam logic [2:0] VIDAS_MAX = 3'd7;

    localparam int TMR_W = 16;

    // 11 is not a command, so only a change onto SOBE/DESCE counts as a press.
    function automatic logic ctrl_edge(input logic [1:0] cur, input logic [1:0] prev);
        return (cur != prev) && (cur == CTRL_SOBE || cur == CTRL_DESCE);
    endfunction

endpackage

// File: rtl/controle_jogo_drone_if.sv
// Strobes to and flags from the position/obstacle datapath.
interface controle_jogo_drone_if;
    logic       zera_jogo;
    logic       move_pulso;
    logic [1:0] move_dir;
    logic       colisao;
    logic       fim_percurso;

    modport master (output zera_jogo, move_pulso, move_dir,
                    input  colisao, fim_percurso);
    modport slave  (input  zera_jogo, move_pulso, move_dir,
                    output colisao, fim_percurso);
endinterface

// File: rtl/drone_tick_timer.sv
// Movement-period counter: fim marks the tc-th enabled cycle since the last clear.
module drone_tick_timer
    import drone_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [TMR_W-1:0] tc,
    output logic             fim
);

    logic [TMR_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en)
            count_d = count_q + TMR_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    // Raised on the last waiting cycle so the caller leaves after exactly tc cycles.
    assign fim = en && (count_q == tc - TMR_W'(1));

endmodule

// File: rtl/controle_jogo_drone.sv
// Game sequencer: menus, periodic movement ticks, collision/finish handling, win/lose.
module controle_jogo_drone
    import drone_pkg::*;
#(
    parameter int TICK_FACIL   = 2000,
    parameter int TICK_MEDIO   = 1000,
    parameter int TICK_DIFICIL = 500
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  iniciar,
    input  logic [1:0]            controle,
    input  logic                  confirma,
    controle_jogo_drone_if.master dp,
    output logic                  venceu,
    output logic                  perdeu,
    output logic [3:0]            db_estado,
    output logic [1:0]            db_modo,
    output logic [2:0]            vidas,
    output logic [2:0]            colisao_counter_out
);

    // MOVE and VERIFICA take one cycle each, so the wait is two short of the period.
    localparam logic [TMR_W-1:0] TC_FACIL   = TMR_W'(TICK_FACIL - 2);
    localparam logic [TMR_W-1:0] TC_MEDIO   = TMR_W'(TICK_MEDIO - 2);
    localparam logic [TMR_W-1:0] TC_DIFICIL = TMR_W'(TICK_DIFICIL - 2);

    estado_t          estado_q, estado_d;
    logic [1:0]       ctrl_prev_q, ctrl_prev_d;
    logic             conf_prev_q, conf_prev_d;
    logic [1:0]       modo_q, modo_d;
    logic [2:0]       vidas_q, vidas_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [1:0]       dir_q, dir_d;
    logic [TMR_W-1:0] tc_q, tc_d;
    logic             ctrl_ev, conf_ev;
    logic             tmr_clr, tmr_en, tmr_fim;

    assign ctrl_ev = ctrl_edge(controle, ctrl_prev_q);
    assign conf_ev = confirma & ~conf_prev_q;

    always_ff @(posedge clock) begin
        if (reset) estado_q <= INICIAL;
        else       estado_q <= estado_d;
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:       if (iniciar) estado_d = PREPARA;
            PREPARA:       estado_d = ESCOLHE_MODO;
            ESCOLHE_MODO:  if (conf_ev) estado_d = ESCOLHE_VIDAS;
            ESCOLHE_VIDAS: if (conf_ev) estado_d = AGUARDA_TICK;
            AGUARDA_TICK:  if (tmr_fim) estado_d = MOVE;
            MOVE:          estado_d = VERIFICA;
            VERIFICA: begin
                if (dp.colisao)
                    estado_d = (vidas_q == VIDAS_MIN) ? PERDEU : COLIDIU;
                else if (dp.fim_percurso)
                    estado_d = VENCEU;
                else
                    estado_d = AGUARDA_TICK;
            end
            COLIDIU:       estado_d = AGUARDA_TICK;
            VENCEU,
            PERDEU:        if (iniciar) estado_d = PREPARA;
            default:       estado_d = INICIAL;
        endcase
    end

    always_comb begin
        ctrl_prev_d = controle;
        conf_prev_d = confirma;
        modo_d      = modo_q;
        vidas_d     = vidas_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        tc_d        = tc_q;
        tmr_en      = (estado_q == AGUARDA_TICK);
        tmr_clr     = !tmr_en;
        case (estado_q)
            PREPARA: begin
                modo_d  = MODO_FACIL;
                vidas_d = VIDAS_MIN;
                cnt_d   = '0;
            end
            ESCOLHE_MODO: if (ctrl_ev) begin
                if (controle == CTRL_SOBE)
                    modo_d = (modo_q == MODO_DIFICIL) ? MODO_FACIL : modo_q + 2'd1;
                else
                    modo_d = (modo_q == MODO_FACIL) ? MODO_DIFICIL : modo_q - 2'd1;
            end
            ESCOLHE_VIDAS: begin
                if (ctrl_ev && controle == CTRL_SOBE && vidas_q != VIDAS_MAX)
                    vidas_d = vidas_q + 3'd1;
                else if (ctrl_ev && controle == CTRL_DESCE && vidas_q != VIDAS_MIN)
                    vidas_d = vidas_q - 3'd1;
                if (conf_ev) begin
                    case (modo_q)
                        MODO_MEDIO:   tc_d = TC_MEDIO;
                        MODO_DIFICIL: tc_d = TC_DIFICIL;
                        default:      tc_d = TC_FACIL;
                    endcase
                end
            end
            MOVE:     dir_d = (controle == 2'b11) ? CTRL_NADA : controle;
            VERIFICA: if (dp.colisao) begin
                vidas_d = vidas_q - 3'd1;
                cnt_d   = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_prev_q <= CTRL_NADA;
            conf_prev_q <= 1'b0;
            modo_q      <= MODO_FACIL;
            vidas_q     <= VIDAS_MIN;
            cnt_q       <= '0;
            dir_q       <= CTRL_NADA;
            tc_q        <= TC_FACIL;
        end else begin
            ctrl_prev_q <= ctrl_prev_d;
            conf_prev_q <= conf_prev_d;
            modo_q      <= modo_d;
            vidas_q     <= vidas_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            tc_q        <= tc_d;
        end
    end

    drone_tick_timer u_tmr (
        .clock (clock),
        .reset (reset),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .tc    (tc_q),
        .fim   (tmr_fim)
    );

    assign dp.zera_jogo         = (estado_q == PREPARA);
    assign dp.move_pulso        = (estado_q == MOVE);
    assign dp.move_dir          = dir_q;
    assign venceu               = (estado_q == VENCEU);
    assign perdeu               = (estado_q == PERDEU);
    assign db_estado            = estado_q;
    assign db_modo              = modo_q;
    assign vidas                = vidas_q;
    assign colisao_counter_out  = cnt_q;

endmodule
